// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - multi-digit time-multiplexed scan driver feeding seg_dec
module seg_scan #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  input  logic                lz_en,
  output logic [3:0]          num,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                frame_done
);

  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CMAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
  localparam logic [CW-1:0] SHOW_LOAD  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYC - 1);

  typedef enum logic {ST_SHOW, ST_BLANK} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                pending_q, pending_d;
  logic [3:0]          num_q, num_d;
  logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic                frame_done_q, frame_done_d;
  logic                boundary;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [3:0] nibble(input logic [4*DIGITS-1:0] v, input logic [IW-1:0] i);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (i == IW'(k)) r = v[4*k +: 4];
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] one_hot(input logic [IW-1:0] i);
    logic [DIGITS-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[k] = (i == IW'(k));
    end
    return r;
  endfunction

  // A digit above 0 goes dark only when it and every more significant nibble are zero.
  function automatic logic digit_lit(input logic [4*DIGITS-1:0] v, input logic [IW-1:0] i,
                                     input logic lz);
    logic upper_nz;
    upper_nz = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) >= i) upper_nz = upper_nz | (v[4*k +: 4] != 4'd0);
    end
    return !lz || (i == '0) || upper_nz;
  endfunction

  // Next-state logic: slot sequencing, double-buffer commit and registered output values.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q - 1'b1;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q | load;
    boundary  = (state_q == ST_BLANK) && (cnt_q == '0) && (idx_q == LAST_IDX);

    if (cnt_q == '0) begin
      if (state_q == ST_SHOW) begin
        state_d = ST_BLANK;
        cnt_d   = BLANK_LOAD;
      end else begin
        state_d = ST_SHOW;
        idx_d   = next_idx(idx_q);
        cnt_d   = SHOW_LOAD;
      end
    end

    if (load) shadow_d = din;

    // Commit takes the shadow as it stood before this edge; a same-cycle load stays pending.
    if (boundary && pending_q) begin
      disp_d    = shadow_q;
      pending_d = load;
    end

    // During BLANK the next digit's nibble is presented early so the decoder settles.
    if (state_d == ST_SHOW) begin
      num_d     = nibble(disp_d, idx_d);
      dig_sel_d = digit_lit(disp_d, idx_d, lz_en) ? one_hot(idx_d) : '0;
    end else begin
      num_d     = nibble(disp_d, next_idx(idx_d));
      dig_sel_d = '0;
    end
    frame_done_d = boundary;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      idx_q        <= LAST_IDX;
      cnt_q        <= BLANK_LOAD;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      num_q        <= '0;
      dig_sel_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      num_q        <= num_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign num        = num_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
Multi-digit time-multiplexed scan driver that sits directly upstream of the team's 7-segment decoder (seg_dec). It holds a DIGITS-wide packed nibble value and presents one nibble at a time on num, which feeds the decoder's num input. It drives a one-hot active-high digit enable with a dead-time blank between digits to suppress ghosting. New values are double-buffered and committed only at frame boundaries, so the display never tears.

Parameters:
DIGITS, 4, number of digits scanned (legal 1..8); digit 0 is least significant/rightmost
SCAN_DIV, 50000, clk cycles each digit is lit (SHOW slot), >=1
BLANK_CYC, 16, clk cycles all digits dark after each SHOW slot, >=1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
load  input  1  capture din into shadow register this cycle
din  input  4*DIGITS  packed nibbles; din[4i+3:4i] = digit i
lz_en  input  1  leading-zero suppression enable (sampled every cycle)
num  output  4  nibble for the decoder; registered
dig_sel  output  DIGITS  one-hot active-high digit enable; bit i = digit i; registered
frame_done  output  1  single-cycle pulse at each frame boundary

Behaviour:
- Single clock and one reset: one clock (clk); reset (rst) is synchronous and active-high.
- Registers: shadow (4*DIGITS), disp (4*DIGITS), pending flag, idx (digit index), down-counter cnt, state {SHOW, BLANK}.
- Reset values: state=BLANK, idx=DIGITS-1, cnt=BLANK_CYC-1, shadow=0, disp=0, pending=0.
- Output reset values: num=0, dig_sel=0, frame_done=0.
- Reset mid-operation returns every register to its reset value on the next edge. Any in-flight load is lost.
- SHOW:
  - dig_sel = one-hot(idx), except when suppressed (see below); num = disp nibble idx.
  - cnt counts SCAN_DIV-1 down to 0.
  - At cnt==0: go to BLANK, cnt=BLANK_CYC-1, dig_sel=0, and num switches to the nibble of the next index so the decoder settles before lighting.
- BLANK:
  - dig_sel=0; cnt counts down.
  - At cnt==0: idx = (idx==DIGITS-1) ? 0 : idx+1, state=SHOW, cnt=SCAN_DIV-1.
- Frame boundary: the final BLANK cycle of digit DIGITS-1. On that cycle's edge:
  - frame_done=1 for exactly one cycle, coincident with the first SHOW cycle of digit 0.
  - If pending, disp<=shadow and pending<=0.
- Frame period = DIGITS*(SCAN_DIV+BLANK_CYC) cycles. After reset release, the first boundary occurs after BLANK_CYC cycles.
- load (any cycle): shadow<=din, pending<=1. Multiple loads within one frame: the last one wins.
- load on the boundary cycle itself: the commit uses the old shadow. The new din lands in shadow and pending stays 1, so it commits at the following boundary.
- Leading-zero suppression, when lz_en=1: digit i>0 is dark (dig_sel all 0 during its SHOW slot) iff disp nibbles i..DIGITS-1 are all 0.
  - Digit 0 is always lit.
  - num still carries the nibble; timing is unchanged.
- Nibbles 10..15 pass through unmodified; rendering them is the decoder's job.
- dig_sel never has more than one bit set. The same dig_sel bit is never asserted on consecutive SHOW slots without an intervening BLANK (except when DIGITS=1, where BLANK still separates slots).

Test Plan:
Use DIGITS=4, SCAN_DIV=4, BLANK_CYC=2 (frame = 24 cycles).
1. Release rst -> dig_sel=0 and num=0 for 2 cycles. Then frame_done pulses 1 cycle while dig_sel=4'b0001 for 4 cycles. Then 0000 x2, 0010 x4, 0000 x2, 0100..., 1000..., and the sequence repeats every 24 cycles.
2. Mid-frame load din=16'h1234 -> slots keep showing 0 until the next frame_done. Then num per slot = 4,3,2,1 for dig_sel 0001,0010,0100,1000.
3. Two loads in one frame (16'h1111 then 16'h5678) -> after the boundary, the slots show 8,7,6,5; 1111 never appears.
4. load din=16'h9999 exactly on the boundary cycle -> the old value is shown for that whole next frame; 9s appear only after the following frame_done.
5. lz_en=1, disp=16'h0040 -> slots 3 and 2 have dig_sel=0; slot 1 shows num=4; slot 0 shows num=0. With disp=16'h0000, only slot 0 lights. With lz_en=0, all four slots light.
6. Assert rst during digit 2 SHOW after disp=16'hABCD -> next cycle num=0, dig_sel=0, disp=0. The restart timing is identical to scenario 1.
